// File: rtl/layer1_addr_seq.sv
// rtl/layer1_addr_seq.sv - layer-1 weight/input SRAM address sequencer; optional SEQ_TIMEOUT_EN watchdog
`timescale 1ns/1ps
module layer1_addr_seq #(
    parameter int N_IN    = 784,
    parameter int N_HID   = 200,
    parameter int WADDR_W = 18,
    parameter int IADDR_W = 10,
    parameter int NIDX_W  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               hold,
    input  logic               mac1_done,
    output logic [WADDR_W-1:0] address_1,
    output logic [IADDR_W-1:0] address_3,
    output logic               addr_valid,
    output logic               mac1_start,
    output logic [NIDX_W-1:0]  neuron_idx,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [IADDR_W-1:0] A3_LAST   = IADDR_W'(N_IN - 1);
    localparam logic [NIDX_W-1:0]  NIDX_LAST = NIDX_W'(N_HID - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_FLUSH,
        S_WAIT,
        S_FIN
    } state_t;

    state_t               state, state_nx;
    logic [WADDR_W-1:0]   a1_nx;
    logic [IADDR_W-1:0]   a3_nx;
    logic [NIDX_W-1:0]    nidx_nx;
    logic                 av_nx, ms_nx, busy_nx, done_nx, err_nx;
    logic                 timed_out;

`ifdef SEQ_TIMEOUT_EN
    localparam int                 TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0]  T_LAST = TCNT_W'(TIMEOUT - 1);
    logic [TCNT_W-1:0]             wait_cnt;

    // Counter is zero in every other state, so it restarts on each WAIT_DONE entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + TCNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    assign timed_out = (wait_cnt == T_LAST);
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT != 0);
    assign timed_out      = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        a1_nx    = address_1;
        a3_nx    = address_3;
        nidx_nx  = neuron_idx;
        av_nx    = 1'b0;
        ms_nx    = 1'b0;
        busy_nx  = 1'b1;
        done_nx  = 1'b0;
        err_nx   = err;
        case (state)
            S_IDLE: begin
                busy_nx = 1'b0;
                if (start) begin
                    state_nx = S_FETCH;
                    a1_nx    = '0;
                    a3_nx    = '0;
                    nidx_nx  = '0;
                    av_nx    = 1'b1;
                    busy_nx  = 1'b1;
                end
            end
            S_FETCH: begin
                // The address on the bus was read in its valid cycle; hold only stalls the advance.
                if (hold) begin
                    av_nx = 1'b0;
                end else if (address_3 == A3_LAST) begin
                    state_nx = S_FLUSH;
                    ms_nx    = 1'b1;
                end else begin
                    a1_nx = address_1 + WADDR_W'(1);
                    a3_nx = address_3 + IADDR_W'(1);
                    av_nx = 1'b1;
                end
            end
            S_FLUSH: begin
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (mac1_done) begin
                    if (neuron_idx == NIDX_LAST) begin
                        state_nx = S_FIN;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = S_FETCH;
                        nidx_nx  = neuron_idx + NIDX_W'(1);
                        a1_nx    = address_1 + WADDR_W'(1);
                        a3_nx    = '0;
                        av_nx    = 1'b1;
                    end
                end else if (timed_out) begin
                    state_nx = S_IDLE;
                    err_nx   = 1'b1;
                    busy_nx  = 1'b0;
                end
            end
            S_FIN: begin
                state_nx = S_IDLE;
                busy_nx  = 1'b0;
            end
            default: begin
                state_nx = S_IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            address_1  <= '0;
            address_3  <= '0;
            neuron_idx <= '0;
            addr_valid <= 1'b0;
            mac1_start <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nx;
            address_1  <= a1_nx;
            address_3  <= a3_nx;
            neuron_idx <= nidx_nx;
            addr_valid <= av_nx;
            mac1_start <= ms_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            err        <= err_nx;
        end
    end

endmodule

// File: tb/tb_layer1_addr_seq.sv
// tb/tb_layer1_addr_seq.sv - randomized self-checking bench for layer1_addr_seq
`timescale 1ns/1ps
module tb_layer1_addr_seq;

    localparam int N_IN  = 4;
    localparam int N_HID = 3;
    localparam int TOTAL = N_IN * N_HID;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, hold, mac1_done;
    logic [17:0] address_1;
    logic [9:0]  address_3;
    logic        addr_valid, mac1_start, busy, done, err;
    logic [7:0]  neuron_idx;

    int checks = 0;
    int errors = 0;

    int exp_k, ms_cnt, done_cnt, fcyc, holds, pend, since_ms;
    bit in_fetch, prev_fetch_hold;
    logic [17:0] prev_a1;
    logic [9:0]  prev_a3;

    layer1_addr_seq #(
        .N_IN(N_IN), .N_HID(N_HID), .WADDR_W(18), .IADDR_W(10), .NIDX_W(8), .TIMEOUT(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .hold(hold), .mac1_done(mac1_done),
        .address_1(address_1), .address_3(address_3), .addr_valid(addr_valid),
        .mac1_start(mac1_start), .neuron_idx(neuron_idx), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_a1"}, 32'(address_1), 0);
        chk({pfx, "_a3"}, 32'(address_3), 0);
        chk({pfx, "_valid"}, 32'(addr_valid), 0);
        chk({pfx, "_mstart"}, 32'(mac1_start), 0);
        chk({pfx, "_nidx"}, 32'(neuron_idx), 0);
        chk({pfx, "_busy"}, 32'(busy), 0);
        chk({pfx, "_done"}, 32'(done), 0);
        chk({pfx, "_err"}, 32'(err), 0);
    endtask

    // d: MAC response in cycles after mac1_start (0 = never answer)
    task automatic run_pass(input int d, input int hold_pct, input bit spur,
                            input int hold_at, input int abort_k, input int budget);
        int  hrun = 0;
        int  tail = -1;
        bit  finished = 0;
        bit  real_done;
        exp_k = 0; ms_cnt = 0; done_cnt = 0; pend = 0; since_ms = -1;
        prev_fetch_hold = 0;
        @(negedge clk);
        start = 1; hold = 0; mac1_done = 0;
        in_fetch = 1; fcyc = 0; holds = 0;
        for (int cyc = 0; cyc < budget && !finished; cyc++) begin
            @(negedge clk);
            if (prev_fetch_hold) begin
                chk("hold_valid_low", 32'(addr_valid), 0);
                chk("hold_a1_frozen", 32'(address_1), 32'(prev_a1));
                chk("hold_a3_frozen", 32'(address_3), 32'(prev_a3));
            end
            if (mac1_start) begin
                chk("fetch_len", fcyc, N_IN + holds);
                in_fetch = 0;
                ms_cnt++;
                chk("reads_before_mstart", exp_k, ms_cnt * N_IN);
                since_ms = 0;
            end else if (since_ms >= 0) begin
                since_ms++;
            end
            if (addr_valid) begin
                chk("a1_seq", 32'(address_1), exp_k);
                chk("a3_seq", 32'(address_3), exp_k % N_IN);
                chk("nidx_seq", 32'(neuron_idx), exp_k / N_IN);
                if (exp_k == hold_at) hrun = 3;
                exp_k++;
            end
            if (done) begin
                done_cnt++;
                chk("final_a1", 32'(address_1), TOTAL - 1);
                chk("final_nidx", 32'(neuron_idx), N_HID - 1);
                chk("mstart_count", ms_cnt, N_HID);
                chk("read_count", exp_k, TOTAL);
                chk("err_clear", 32'(err), 0);
                tail = 3;
            end
`ifdef SEQ_TIMEOUT_EN
            if (err && tail < 0) begin
                chk("err_latency", since_ms, 9);
                chk("timeout_idle", 32'(busy), 0);
                chk("timeout_no_done", done_cnt, 0);
                tail = 3;
            end
`endif
            if (abort_k >= 0 && exp_k == abort_k) begin
                reset = 1'b0;
                start = 0; hold = 0; mac1_done = 0;
                #1;
                chk_zero("async_reset");
                @(negedge clk);
                reset = 1'b1;
                finished = 1;
            end else begin
                if (tail > 0) tail--;
                if (tail == 0) begin
                    chk("busy_after", 32'(busy), 0);
                    chk("done_once", done_cnt, (d > 0) ? 1 : 0);
                    finished = 1;
                end
                hold = (hrun > 0) ? 1'b1 : ($urandom_range(0, 99) < hold_pct);
                if (hrun > 0) hrun--;
                mac1_done = 0;
                real_done = 0;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        mac1_done = 1;
                        real_done = 1;
                    end
                end
                if (mac1_start && d > 0) pend = d;
                if (spur && addr_valid && $urandom_range(0, 3) == 0) mac1_done = 1;
                start = spur && busy && ($urandom_range(0, 3) == 0);
                if (in_fetch) begin
                    fcyc++;
                    if (hold) holds++;
                end
                prev_fetch_hold = in_fetch && hold;
                prev_a1 = address_1;
                prev_a3 = address_3;
                if (real_done && ms_cnt < N_HID) begin
                    in_fetch = 1; fcyc = 0; holds = 0;
                end
            end
        end
        if (!finished) chk("pass_budget", 0, 1);
        start = 0; hold = 0; mac1_done = 0;
    endtask

    initial begin
        reset = 1'b0; start = 0; hold = 0; mac1_done = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        reset = 1'b1;

        run_pass(2, 0, 0, -1, -1, 500);
        run_pass(1, 0, 0, 2, -1, 500);
        run_pass(2, 0, 0, -1, N_IN + 2, 500);
        @(negedge clk);
        chk_zero("post_reset");
        run_pass(3, 0, 1, -1, -1, 500);
        for (int p = 0; p < 4; p++) begin
            run_pass(int'($urandom_range(1, 5)), 30, 1, int'($urandom_range(0, TOTAL - 1)), -1, 2000);
        end
`ifdef SEQ_TIMEOUT_EN
        run_pass(0, 20, 0, -1, -1, 500);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
